// File: rtl/control_unit.sv
// Hardwired control unit: Moore sequencer (RESET, T0-T7, PAUSE, HALT) driving every
// datapath control input from the current step and the IR opcode.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic        stop,
    input  logic [31:0] IR,
    input  logic        CON,
    output logic        run,
    output logic        Read,
    output logic        Write,
    output logic        IncPC,
    output logic        PC_enable,
    output logic        Z_enable,
    output logic        MDR_enable,
    output logic        MAR_enable,
    output logic        Y_enable,
    output logic        HI_enable,
    output logic        LO_enable,
    output logic        IR_enable,
    output logic        OutPort_enable,
    output logic        PCout,
    output logic        ZHighout,
    output logic        ZLowout,
    output logic        HIout,
    output logic        LOout,
    output logic        MDRout,
    output logic        InPortout,
    output logic        Cout,
    output logic        BAout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        CONin,
    output logic [15:0] R0_15_in_enable_in,
    output logic [15:0] R0_15_out_enable_in
);

    typedef enum logic [3:0] {
        StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StPause, StHalt
    } state_e;

    localparam logic [4:0] OpLd   = 5'b00000, OpLdi  = 5'b00001, OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011, OpSub  = 5'b00100, OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110, OpRor  = 5'b00111, OpRol  = 5'b01000;
    localparam logic [4:0] OpShr  = 5'b01001, OpShra = 5'b01010, OpShl  = 5'b01011;
    localparam logic [4:0] OpAddi = 5'b01100, OpAndi = 5'b01101, OpOri  = 5'b01110;
    localparam logic [4:0] OpMul  = 5'b01111, OpDiv  = 5'b10000, OpNeg  = 5'b10001;
    localparam logic [4:0] OpNot  = 5'b10010, OpBr   = 5'b10011, OpJr   = 5'b10100;
    localparam logic [4:0] OpJal  = 5'b10101, OpIn   = 5'b10110, OpOut  = 5'b10111;
    localparam logic [4:0] OpMfhi = 5'b11000, OpMflo = 5'b11001, OpHalt = 5'b11011;

    state_e     r_state;
    logic [4:0] w_op;
    state_e     w_last;
    logic       w_alu, w_imm, w_mem, w_muldiv, w_negnot;

    assign w_op = IR[31:27];

    always_comb begin
        w_alu    = (w_op >= OpAdd) && (w_op <= OpShl);
        w_imm    = (w_op == OpAddi) || (w_op == OpAndi) || (w_op == OpOri) || (w_op == OpLdi);
        w_mem    = (w_op == OpLd) || (w_op == OpSt);
        w_muldiv = (w_op == OpMul) || (w_op == OpDiv);
        w_negnot = (w_op == OpNeg) || (w_op == OpNot);
        case (w_op)
            OpLd, OpSt:                            w_last = StT7;
            OpMul, OpDiv, OpBr:                    w_last = StT6;
            OpNeg, OpNot, OpJal:                   w_last = StT4;
            OpJr, OpIn, OpOut, OpMfhi, OpMflo:     w_last = StT3;
            default:                               w_last = (w_alu || w_imm) ? StT5 : StT2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= StReset;
        end else begin
            case (r_state)
                StReset: r_state <= StT0;
                StT0:    r_state <= stop ? StPause : StT1;
                StT1:    r_state <= StT2;
                StT2:    r_state <= (w_op == OpHalt) ? StHalt :
                                    (w_last == StT2) ? StT0 : StT3;
                StT3:    r_state <= (w_last == StT3) ? StT0 : StT4;
                StT4:    r_state <= (w_last == StT4) ? StT0 : StT5;
                StT5:    r_state <= (w_last == StT5) ? StT0 : StT6;
                StT6:    r_state <= (w_last == StT6) ? StT0 : StT7;
                StT7:    r_state <= StT0;
                StPause: r_state <= stop ? StPause : StT0;
                StHalt:  r_state <= StHalt;
                default: r_state <= StReset;
            endcase
        end
    end

    assign R0_15_out_enable_in = '0;

    // Decoded combinationally: IR is only loaded on the edge leaving T2, so a registered
    // decode would see the previous instruction in T3.
    always_comb begin
        run = 1'b0;  Read = 1'b0;  Write = 1'b0;  IncPC = 1'b0;
        PC_enable = 1'b0;  Z_enable = 1'b0;  MDR_enable = 1'b0;  MAR_enable = 1'b0;
        Y_enable = 1'b0;  HI_enable = 1'b0;  LO_enable = 1'b0;  IR_enable = 1'b0;
        OutPort_enable = 1'b0;  PCout = 1'b0;  ZHighout = 1'b0;  ZLowout = 1'b0;
        HIout = 1'b0;  LOout = 1'b0;  MDRout = 1'b0;  InPortout = 1'b0;  Cout = 1'b0;
        BAout = 1'b0;  Gra = 1'b0;  Grb = 1'b0;  Grc = 1'b0;  Rin = 1'b0;  Rout = 1'b0;
        CONin = 1'b0;  R0_15_in_enable_in = '0;
        run = (r_state >= StT0) && (r_state <= StT7);
        case (r_state)
            StT0: if (!stop) begin
                PCout = 1'b1;  MAR_enable = 1'b1;  IncPC = 1'b1;  Z_enable = 1'b1;
            end
            StT1: begin
                ZLowout = 1'b1;  PC_enable = 1'b1;  Read = 1'b1;  MDR_enable = 1'b1;
            end
            StT2: begin
                MDRout = 1'b1;  IR_enable = 1'b1;
            end
            StT3: begin
                if (w_alu || w_imm || w_mem) begin
                    Grb = 1'b1;  Y_enable = 1'b1;
                    BAout = w_mem || (w_op == OpLdi);
                    Rout  = !BAout;
                end
                if (w_muldiv) begin Gra = 1'b1;  Rout = 1'b1;  Y_enable = 1'b1; end
                if (w_negnot) begin Grb = 1'b1;  Rout = 1'b1;  Z_enable = 1'b1; end
                case (w_op)
                    OpBr:   begin Gra = 1'b1;  Rout = 1'b1;  CONin = 1'b1;  end
                    OpJr:   begin Gra = 1'b1;  Rout = 1'b1;  PC_enable = 1'b1;  end
                    OpJal:  begin PCout = 1'b1;  R0_15_in_enable_in[15] = 1'b1;  end
                    OpIn:   begin InPortout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;  end
                    OpOut:  begin Gra = 1'b1;  Rout = 1'b1;  OutPort_enable = 1'b1;  end
                    OpMfhi: begin HIout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;  end
                    OpMflo: begin LOout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;  end
                    default: ;
                endcase
            end
            StT4: begin
                if (w_alu)            begin Grc = 1'b1;  Rout = 1'b1;  Z_enable = 1'b1;  end
                if (w_imm || w_mem)   begin Cout = 1'b1;  Z_enable = 1'b1;  end
                if (w_muldiv)         begin Grb = 1'b1;  Rout = 1'b1;  Z_enable = 1'b1;  end
                if (w_negnot)         begin ZLowout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;  end
                if (w_op == OpBr)     begin PCout = 1'b1;  Y_enable = 1'b1;  end
                if (w_op == OpJal)    begin Gra = 1'b1;  Rout = 1'b1;  PC_enable = 1'b1;  end
            end
            StT5: begin
                if (w_alu || w_imm)   begin ZLowout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;  end
                if (w_mem)            begin ZLowout = 1'b1;  MAR_enable = 1'b1;  end
                if (w_muldiv)         begin ZLowout = 1'b1;  LO_enable = 1'b1;  end
                if (w_op == OpBr)     begin Cout = 1'b1;  Z_enable = 1'b1;  end
            end
            StT6: begin
                if (w_op == OpLd)     begin Read = 1'b1;  MDR_enable = 1'b1;  end
                if (w_op == OpSt)     begin Gra = 1'b1;  Rout = 1'b1;  MDR_enable = 1'b1;  end
                if (w_muldiv)         begin ZHighout = 1'b1;  HI_enable = 1'b1;  end
                // Taken-branch PC load is the one input-dependent term in the step.
                if (w_op == OpBr)     begin ZLowout = 1'b1;  PC_enable = CON;  end
            end
            StT7: begin
                if (w_op == OpLd)     begin MDRout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;  end
                if (w_op == OpSt)     Write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: a per-instruction step table predicts every cycle's
// control word into a queue; a monitor compares the DUT output word each cycle.
module tb_control_unit;

    typedef logic [59:0] word_t;

    localparam word_t K_RUN  = word_t'(1) << 0,  K_READ  = word_t'(1) << 1;
    localparam word_t K_WR   = word_t'(1) << 2,  K_INC   = word_t'(1) << 3;
    localparam word_t K_PCE  = word_t'(1) << 4,  K_ZE    = word_t'(1) << 5;
    localparam word_t K_MDRE = word_t'(1) << 6,  K_MARE  = word_t'(1) << 7;
    localparam word_t K_YE   = word_t'(1) << 8,  K_HIE   = word_t'(1) << 9;
    localparam word_t K_LOE  = word_t'(1) << 10, K_IRE   = word_t'(1) << 11;
    localparam word_t K_OUTE = word_t'(1) << 12, K_PCO   = word_t'(1) << 13;
    localparam word_t K_ZHI  = word_t'(1) << 14, K_ZLO   = word_t'(1) << 15;
    localparam word_t K_HIO  = word_t'(1) << 16, K_LOO   = word_t'(1) << 17;
    localparam word_t K_MDRO = word_t'(1) << 18, K_INP   = word_t'(1) << 19;
    localparam word_t K_C    = word_t'(1) << 20, K_BA    = word_t'(1) << 21;
    localparam word_t K_GRA  = word_t'(1) << 22, K_GRB   = word_t'(1) << 23;
    localparam word_t K_GRC  = word_t'(1) << 24, K_RIN   = word_t'(1) << 25;
    localparam word_t K_ROUT = word_t'(1) << 26, K_CONIN = word_t'(1) << 27;
    localparam word_t K_R15  = word_t'(1) << 43;

    logic clk = 1'b0, clr = 1'b1, stop = 1'b0, CON = 1'b0;
    logic [31:0] IR = '0;
    logic run, Read, Write, IncPC, PC_enable, Z_enable, MDR_enable, MAR_enable, Y_enable;
    logic HI_enable, LO_enable, IR_enable, OutPort_enable, PCout, ZHighout, ZLowout, HIout;
    logic LOout, MDRout, InPortout, Cout, BAout, Gra, Grb, Grc, Rin, Rout, CONin;
    logic [15:0] R0_15_in_enable_in, R0_15_out_enable_in;

    control_unit dut (
        .clk(clk), .clr(clr), .stop(stop), .IR(IR), .CON(CON), .run(run), .Read(Read),
        .Write(Write), .IncPC(IncPC), .PC_enable(PC_enable), .Z_enable(Z_enable),
        .MDR_enable(MDR_enable), .MAR_enable(MAR_enable), .Y_enable(Y_enable),
        .HI_enable(HI_enable), .LO_enable(LO_enable), .IR_enable(IR_enable),
        .OutPort_enable(OutPort_enable), .PCout(PCout), .ZHighout(ZHighout),
        .ZLowout(ZLowout), .HIout(HIout), .LOout(LOout), .MDRout(MDRout),
        .InPortout(InPortout), .Cout(Cout), .BAout(BAout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .CONin(CONin), .R0_15_in_enable_in(R0_15_in_enable_in),
        .R0_15_out_enable_in(R0_15_out_enable_in)
    );

    always #5 clk = ~clk;

    word_t exp_q[$];
    word_t seq[$];
    int    n_cmp = 0, n_bad = 0;

    word_t act;
    assign act = {R0_15_out_enable_in, R0_15_in_enable_in, CONin, Rout, Rin, Grc, Grb, Gra,
                  BAout, Cout, InPortout, MDRout, LOout, HIout, ZLowout, ZHighout, PCout,
                  OutPort_enable, IR_enable, LO_enable, HI_enable, Y_enable, MAR_enable,
                  MDR_enable, Z_enable, PC_enable, IncPC, Write, Read, run};

    // Monitor: one expected word per cycle, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
            word_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL ctrl_word @%0t: got %h want %h", $time, act, e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick(input word_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Step table of control words for one instruction, fetch included (T0 first).
    task automatic build(input logic [4:0] op, input logic con);
        seq = {};
        seq.push_back(K_PCO | K_MARE | K_INC | K_ZE);
        seq.push_back(K_ZLO | K_PCE | K_READ | K_MDRE);
        seq.push_back(K_MDRO | K_IRE);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
                seq.push_back(K_GRB | K_ROUT | K_YE);
                seq.push_back(K_GRC | K_ROUT | K_ZE);
                seq.push_back(K_ZLO | K_GRA | K_RIN);
            end
            5'd1, 5'd12, 5'd13, 5'd14: begin
                seq.push_back(K_GRB | K_YE | ((op == 5'd1) ? K_BA : K_ROUT));
                seq.push_back(K_C | K_ZE);
                seq.push_back(K_ZLO | K_GRA | K_RIN);
            end
            5'd0, 5'd2: begin
                seq.push_back(K_GRB | K_BA | K_YE);
                seq.push_back(K_C | K_ZE);
                seq.push_back(K_ZLO | K_MARE);
                if (op == 5'd0) begin
                    seq.push_back(K_READ | K_MDRE);
                    seq.push_back(K_MDRO | K_GRA | K_RIN);
                end else begin
                    seq.push_back(K_GRA | K_ROUT | K_MDRE);
                    seq.push_back(K_WR);
                end
            end
            5'd15, 5'd16: begin
                seq.push_back(K_GRA | K_ROUT | K_YE);
                seq.push_back(K_GRB | K_ROUT | K_ZE);
                seq.push_back(K_ZLO | K_LOE);
                seq.push_back(K_ZHI | K_HIE);
            end
            5'd17, 5'd18: begin
                seq.push_back(K_GRB | K_ROUT | K_ZE);
                seq.push_back(K_ZLO | K_GRA | K_RIN);
            end
            5'd19: begin
                seq.push_back(K_GRA | K_ROUT | K_CONIN);
                seq.push_back(K_PCO | K_YE);
                seq.push_back(K_C | K_ZE);
                seq.push_back(K_ZLO | (con ? K_PCE : word_t'(0)));
            end
            5'd20: seq.push_back(K_GRA | K_ROUT | K_PCE);
            5'd21: begin
                seq.push_back(K_PCO | K_R15);
                seq.push_back(K_GRA | K_ROUT | K_PCE);
            end
            5'd22: seq.push_back(K_INP | K_GRA | K_RIN);
            5'd23: seq.push_back(K_GRA | K_ROUT | K_OUTE);
            5'd24: seq.push_back(K_HIO | K_GRA | K_RIN);
            5'd25: seq.push_back(K_LOO | K_GRA | K_RIN);
            default: ;
        endcase
    endtask

    task automatic reset_seq(input int n);
        clr = 1'b1;
        repeat (n) tick('0);
        clr = 1'b0;
        tick('0);
    endtask

    // stop raised in T0: that cycle shows only run, then PAUSE until released.
    task automatic stall(input int k);
        stop = 1'b1;
        tick(K_RUN);
        repeat (k) tick('0);
        stop = 1'b0;
        tick('0);
    endtask

    task automatic do_instr(input logic [4:0] op, input logic con, input int clr_at,
                            input int halt_hold);
        logic [31:0] r;
        r = $urandom();
        IR = {op, r[26:0]};
        CON = con;
        build(op, con);
        for (int i = 0; i < seq.size(); i++) begin
            stop = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            clr = (i == clr_at) && (op != 5'd27);
            tick(seq[i] | K_RUN);
            if (clr) begin
                clr = 1'b0;
                tick('0);
                return;
            end
        end
        stop = 1'b0;
        if (op == 5'd27) begin
            for (int i = 0; i < halt_hold; i++) begin
                stop = 1'($urandom_range(0, 1));
                tick('0);
            end
            reset_seq(1);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        reset_seq(2);
        do_instr(5'd3, 1'b0, -1, 0);   // add
        do_instr(5'd0, 1'b1, -1, 0);   // ld
        do_instr(5'd2, 1'b0, -1, 0);   // st
        do_instr(5'd19, 1'b1, -1, 0);  // br taken
        do_instr(5'd19, 1'b0, -1, 0);  // br not taken
        do_instr(5'd15, 1'b0, 5, 0);   // mul, clr at T5
        stall(2);
        do_instr(5'd26, 1'b0, -1, 0);  // nop
        do_instr(5'd27, 1'b0, -1, 20); // halt
        do_instr(5'd30, 1'b1, -1, 0);  // undefined -> nop
        for (int n = 0; n < 300; n++) begin
            int ca;
            if ($urandom_range(0, 7) == 0) stall($urandom_range(0, 3));
            ca = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
            do_instr(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), ca, 3);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
